// File: rtl/dac_stream_core.sv
// Multi-channel DAC output stage: buffers sample frames in a FIFO and plays them
// out time-interleaved on one data bus at a programmable slot rate.
module dac_stream_core #(
    parameter  int DAC_WIDTH   = 10,
    parameter  int NUM_CH      = 2,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int PRIME_LEVEL = 4,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        SPLB_Clk,
    input  logic                        SPLB_Rst,
    input  logic                        Ctrl_Enable,
    input  logic [15:0]                 Ctrl_RateDiv,
    input  logic [NUM_CH-1:0]           Ctrl_ChMask,
    input  logic                        Ctrl_PwrDn,
    input  logic                        Wr_Valid,
    output logic                        Wr_Ready,
    input  logic [NUM_CH*DAC_WIDTH-1:0] Wr_Data,
    output logic [LVL_W-1:0]            Fifo_Level,
    output logic                        Stat_Underrun,
    input  logic                        Stat_UnderrunClr,
    output logic [DAC_WIDTH-1:0]        S_Data,
    output logic [CH_W-1:0]             S_ChSel,
    output logic                        S_DCLKIO,
    output logic                        S_PWRDN,
    output logic [NUM_CH-1:0]           S_OpEn
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;

    state_t                        state, nextState;
    logic [NUM_CH*DAC_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wrPtr, rdPtr;
    logic [LVL_W-1:0]              level;
    logic                          full, empty, push, pop;
    logic [NUM_CH*DAC_WIDTH-1:0]   frame;
    logic [NUM_CH-1:0]             mask;
    logic [CH_W-1:0]               chIdx, nxtCh, firstCh;
    logic                          hasNext, slotAdv, underrunEv;
    logic [15:0]                   cnt, slotD, dNew;
    logic [DAC_WIDTH-1:0]          sample;

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign Wr_Ready   = SPLB_Rst & Ctrl_Enable & ~full;
    assign push       = Wr_Valid & Wr_Ready;
    assign Fifo_Level = level;
    assign dNew       = (Ctrl_RateDiv == 16'd0) ? 16'd1 : Ctrl_RateDiv;
    assign S_OpEn     = (state == RUN) ? mask : '0;
    assign S_PWRDN    = Ctrl_PwrDn | (state == IDLE);

    always_ff @(posedge SPLB_Clk)
        if (push) mem[wrPtr] <= Wr_Data;

    // Dropping Ctrl_Enable flushes the buffer in the same edge as the state change.
    always_ff @(posedge SPLB_Clk) begin
        if (!SPLB_Rst || !Ctrl_Enable) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Channel walk: lowest enabled index first, then the next higher enabled one.
    always_comb begin
        firstCh = '0;
        nxtCh   = chIdx;
        hasNext = 1'b0;
        sample  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (Ctrl_ChMask[i]) firstCh = CH_W'(i);
            if (mask[i] && (i > int'(chIdx))) begin
                hasNext = 1'b1;
                nxtCh   = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++)
            if (chIdx == CH_W'(i)) sample = frame[i*DAC_WIDTH +: DAC_WIDTH];
    end

    always_ff @(posedge SPLB_Clk) begin
        if (!SPLB_Rst) state <= IDLE;
        else           state <= nextState;
    end

    always_comb begin
        nextState  = state;
        pop        = 1'b0;
        slotAdv    = 1'b0;
        underrunEv = 1'b0;
        case (state)
            IDLE:     if (|Ctrl_ChMask) nextState = PRIME;
            PRIME: begin
                if (~|Ctrl_ChMask) nextState = IDLE;
                else if (level >= LVL_W'(PRIME_LEVEL)) begin
                    pop       = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    if (hasNext)            slotAdv = 1'b1;
                    else if (~|Ctrl_ChMask) nextState = IDLE;
                    else if (empty) begin
                        nextState  = UNDERRUN;
                        underrunEv = 1'b1;
                    end else                pop = 1'b1;
                end
            end
            UNDERRUN: nextState = PRIME;
            default:  nextState = IDLE;
        endcase
        if (!Ctrl_Enable) begin
            nextState  = IDLE;
            pop        = 1'b0;
            slotAdv    = 1'b0;
            underrunEv = 1'b0;
        end
    end

    // Slot timing; the divider is sampled only at reload so a slot is never cut short.
    always_ff @(posedge SPLB_Clk) begin
        if (!SPLB_Rst) begin
            frame <= '0;
            mask  <= '0;
            chIdx <= '0;
            cnt   <= '0;
            slotD <= 16'd1;
        end else if (pop) begin
            frame <= mem[rdPtr];
            mask  <= Ctrl_ChMask;
            chIdx <= firstCh;
            cnt   <= dNew;
            slotD <= dNew;
        end else if (slotAdv) begin
            chIdx <= nxtCh;
            cnt   <= dNew;
            slotD <= dNew;
        end else if (state == RUN && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge SPLB_Clk) begin
        if (!SPLB_Rst) begin
            S_Data   <= MID;
            S_ChSel  <= '0;
            S_DCLKIO <= 1'b0;
        end else if (nextState != RUN) begin
            S_Data   <= MID;
            S_DCLKIO <= 1'b0;
        end else begin
            S_DCLKIO <= (state == RUN) && (cnt <= (slotD >> 1));
            if (state == RUN && cnt == slotD) begin
                S_Data  <= sample;
                S_ChSel <= chIdx;
            end
        end
    end

    // Set beats clear, both on the detecting edge and during the UNDERRUN cycle.
    always_ff @(posedge SPLB_Clk) begin
        if (!SPLB_Rst)                           Stat_Underrun <= 1'b0;
        else if (underrunEv || state == UNDERRUN) Stat_Underrun <= 1'b1;
        else if (Stat_UnderrunClr)               Stat_Underrun <= 1'b0;
    end
endmodule

// File: tb/tb_dac_stream_core.sv
// Directed bench for dac_stream_core: fixed-cycle stimulus with hand-computed expectations.
module tb_dac_stream_core;
    localparam int W = 10;

    logic          SPLB_Clk = 1'b0;
    logic          SPLB_Rst = 1'b0;
    logic          Ctrl_Enable = 1'b0;
    logic [15:0]   Ctrl_RateDiv = 16'd3;
    logic [1:0]    Ctrl_ChMask = 2'b00;
    logic          Ctrl_PwrDn = 1'b0;
    logic          Wr_Valid = 1'b0;
    logic          Wr_Ready;
    logic [19:0]   Wr_Data = '0;
    logic [4:0]    Fifo_Level;
    logic          Stat_Underrun;
    logic          Stat_UnderrunClr = 1'b0;
    logic [W-1:0]  S_Data;
    logic [0:0]    S_ChSel;
    logic          S_DCLKIO;
    logic          S_PWRDN;
    logic [1:0]    S_OpEn;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dac_stream_core #(.DAC_WIDTH(10), .NUM_CH(2), .FIFO_DEPTH(16), .PRIME_LEVEL(4)) dut (
        .SPLB_Clk(SPLB_Clk), .SPLB_Rst(SPLB_Rst), .Ctrl_Enable(Ctrl_Enable),
        .Ctrl_RateDiv(Ctrl_RateDiv), .Ctrl_ChMask(Ctrl_ChMask), .Ctrl_PwrDn(Ctrl_PwrDn),
        .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data), .Fifo_Level(Fifo_Level),
        .Stat_Underrun(Stat_Underrun), .Stat_UnderrunClr(Stat_UnderrunClr), .S_Data(S_Data),
        .S_ChSel(S_ChSel), .S_DCLKIO(S_DCLKIO), .S_PWRDN(S_PWRDN), .S_OpEn(S_OpEn)
    );

    always #5 SPLB_Clk = ~SPLB_Clk;

    task automatic tick();
        @(posedge SPLB_Clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] frm(input logic [9:0] c0, input logic [9:0] c1);
        return {c1, c0};
    endfunction

    task automatic chkReset(input string pfx);
        chk({pfx, "_level"},   32'(Fifo_Level), 0);
        chk({pfx, "_data"},    32'(S_Data), 32'h200);
        chk({pfx, "_chsel"},   32'(S_ChSel), 0);
        chk({pfx, "_dclk"},    32'(S_DCLKIO), 0);
        chk({pfx, "_pwrdn"},   32'(S_PWRDN), 1);
        chk({pfx, "_open"},    32'(S_OpEn), 0);
        chk({pfx, "_underrun"}, 32'(Stat_Underrun), 0);
        chk({pfx, "_wrready"}, 32'(Wr_Ready), 0);
    endtask

    initial begin
        tick();
        tick();
        chkReset("rst0");

        // Two channels, 4-clock slots, four identical frames then underrun
        SPLB_Rst = 1'b1; Ctrl_Enable = 1'b1; Ctrl_ChMask = 2'b11; Ctrl_RateDiv = 16'd3;
        Wr_Valid = 1'b1; Wr_Data = frm(10'h155, 10'h2AA); cyc = 0;
        goto(4);  chk("a_level4", 32'(Fifo_Level), 4); chk("a_prime_mid", 32'(S_Data), 32'h200);
        Wr_Valid = 1'b0;
        goto(6);  chk("a_s0", 32'(S_Data), 32'h155); chk("a_sel0", 32'(S_ChSel), 0);
                  chk("a_dclk6", 32'(S_DCLKIO), 0); chk("a_open", 32'(S_OpEn), 3);
                  chk("a_pwrdn", 32'(S_PWRDN), 0);
        goto(8);  chk("a_dclk8", 32'(S_DCLKIO), 1);
        goto(10); chk("a_s1", 32'(S_Data), 32'h2AA); chk("a_sel1", 32'(S_ChSel), 1);
                  chk("a_dclk10", 32'(S_DCLKIO), 0);
        goto(13); chk("a_level2", 32'(Fifo_Level), 2);
        goto(14); chk("a_s2", 32'(S_Data), 32'h155);
        goto(21); chk("a_level1", 32'(Fifo_Level), 1);
        goto(29); chk("a_level0", 32'(Fifo_Level), 0);
        goto(35); chk("a_last", 32'(S_Data), 32'h2AA); chk("a_no_ur", 32'(Stat_Underrun), 0);
        goto(37); chk("a_ur_set", 32'(Stat_Underrun), 1); chk("a_ur_mid", 32'(S_Data), 32'h200);
                  chk("a_ur_open", 32'(S_OpEn), 0);
        goto(38); chk("a_prime_pwr", 32'(S_PWRDN), 0);
        Stat_UnderrunClr = 1'b1;
        goto(39); chk("a_ur_clr", 32'(Stat_Underrun), 0);
        Stat_UnderrunClr = 1'b0; Wr_Valid = 1'b1; Wr_Data = frm(10'h0F0, 10'h30F);
        goto(43); chk("a_relevel", 32'(Fifo_Level), 4);
        Wr_Valid = 1'b0;
        goto(45); chk("a_resume0", 32'(S_Data), 32'h0F0);
        goto(49); chk("a_resume1", 32'(S_Data), 32'h30F);
        goto(75); chk("a_pre_ur2", 32'(Stat_Underrun), 0);
        Stat_UnderrunClr = 1'b1;
        goto(76); chk("a_ur_vs_clr", 32'(Stat_Underrun), 1);
        goto(77); chk("a_ur_hold", 32'(Stat_Underrun), 1);
        Stat_UnderrunClr = 1'b0; Ctrl_Enable = 1'b0;
        tick();   chk("a_idle_pwr", 32'(S_PWRDN), 1);

        // Only channel 1 enabled: one pop per slot
        Ctrl_Enable = 1'b1; Ctrl_ChMask = 2'b10; cyc = 0; Wr_Valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Wr_Data = frm(10'h3FF, 10'(10'h100 + k));
            tick();
        end
        Wr_Valid = 1'b0;
        goto(5);  chk("b_level3", 32'(Fifo_Level), 3);
        goto(6);  chk("b_s0", 32'(S_Data), 32'h100); chk("b_sel", 32'(S_ChSel), 1);
                  chk("b_open", 32'(S_OpEn), 2);
        goto(9);  chk("b_level2", 32'(Fifo_Level), 2);
        goto(10); chk("b_s1", 32'(S_Data), 32'h101); chk("b_sel1", 32'(S_ChSel), 1);
        goto(14); chk("b_s2", 32'(S_Data), 32'h102);
        Ctrl_Enable = 1'b0; Ctrl_ChMask = 2'b00; Ctrl_RateDiv = 16'hFFFF;
        tick();

        // Fill to full with no channels enabled, then release with RateDiv=0
        Ctrl_Enable = 1'b1; cyc = 0; Wr_Valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            Wr_Data = frm(10'(10'h040 + k), 10'(10'h300 + k));
            tick();
        end
        chk("c_full", 32'(Fifo_Level), 16); chk("c_notready", 32'(Wr_Ready), 0);
        chk("c_mask0_pwr", 32'(S_PWRDN), 1);
        Wr_Data = frm(10'h050, 10'h310);
        tick();   chk("c_17th_held", 32'(Fifo_Level), 16);
        Ctrl_ChMask = 2'b11; Ctrl_RateDiv = 16'd0;
        tick();   chk("c_prime_full", 32'(Wr_Ready), 0);
        tick();   chk("c_popped", 32'(Fifo_Level), 15); chk("c_ready", 32'(Wr_Ready), 1);
        tick();   chk("c_accept17", 32'(Fifo_Level), 16);
                  chk("c_s0", 32'(S_Data), 32'h040); chk("c_sel0", 32'(S_ChSel), 0);
        Wr_Valid = 1'b0;
        goto(22); chk("c_s1", 32'(S_Data), 32'h300); chk("c_sel1", 32'(S_ChSel), 1);

        // Enable dropped mid-frame, then reset during RUN
        Ctrl_Enable = 1'b0;
        tick();
        chk("d_flush", 32'(Fifo_Level), 0); chk("d_mid", 32'(S_Data), 32'h200);
        chk("d_pwrdn", 32'(S_PWRDN), 1); chk("d_open", 32'(S_OpEn), 0);
        chk("d_dclk", 32'(S_DCLKIO), 0); chk("d_wrready", 32'(Wr_Ready), 0);
        Ctrl_Enable = 1'b1; cyc = 0; Wr_Valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Wr_Data = frm(10'h011, 10'h322);
            tick();
        end
        Wr_Valid = 1'b0;
        goto(8);  chk("d_s1", 32'(S_Data), 32'h322); chk("d_sel1", 32'(S_ChSel), 1);
                  chk("d_open_run", 32'(S_OpEn), 3); chk("d_ur_sticky", 32'(Stat_Underrun), 1);
        SPLB_Rst = 1'b0;
        tick();
        chkReset("rst_run");
        SPLB_Rst = 1'b1; Ctrl_Enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
